// File: rtl/popcount_pkg.sv
// Shared types and constants for the per-frame popcount accumulator.
package popcount_pkg;
  localparam int W_CNT     = 4;
  localparam int MAX_CNT   = 8;
  localparam int W_ACC_DEF = 16;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } popcount_accum_state_t;
endpackage

// File: rtl/popcount_sat_add.sv
// W_ACC-bit adder with carry out; wraps by default, saturates when
// POPCOUNT_ACCUM_SAT_EN is defined.
module popcount_sat_add #(
  parameter int W_ACC = 16
) (
  input  logic [W_ACC-1:0] a,
  input  logic [W_ACC-1:0] b,
  output logic [W_ACC-1:0] sum,
  output logic             carry
);
  logic [W_ACC:0] w_raw;

  assign w_raw = {1'b0, a} + {1'b0, b};
  assign carry = w_raw[W_ACC];

`ifdef POPCOUNT_ACCUM_SAT_EN
  // Pin at all-ones once the true sum no longer fits.
  assign sum = w_raw[W_ACC] ? {W_ACC{1'b1}} : w_raw[W_ACC-1:0];
`else
  assign sum = w_raw[W_ACC-1:0];
`endif
endmodule

// File: rtl/popcount_accum.sv
// Sums per-byte popcounts over an I_LAST-delimited frame and presents total,
// beat count and overflow on a valid/ready port. Option: POPCOUNT_ACCUM_SAT_EN.
import popcount_pkg::*;

module popcount_accum #(
  parameter int W_ACC = W_ACC_DEF
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [W_CNT-1:0] I,
  input  logic             I_VALID,
  input  logic             I_LAST,
  output logic             I_READY,
  output logic [W_ACC-1:0] O,
  output logic [W_ACC-1:0] O_BEATS,
  output logic             O_OVF,
  output logic             O_VALID,
  input  logic             O_READY
);
  popcount_accum_state_t r_state;
  logic [W_ACC-1:0] r_acc;
  logic [W_ACC-1:0] r_beats;
  logic             r_ovf;
  logic [W_ACC-1:0] r_o;
  logic [W_ACC-1:0] r_o_beats;
  logic             r_o_ovf;
  logic             r_o_valid;

  logic [W_ACC-1:0] w_i_ext;
  logic [W_ACC-1:0] w_one;
  logic [W_ACC-1:0] w_acc_sum;
  logic [W_ACC-1:0] w_beats_sum;
  logic             w_acc_carry;
  logic             w_beats_carry;
  logic             w_ovf_next;
  logic             w_accept;

  assign w_i_ext    = {{(W_ACC-W_CNT){1'b0}}, I};
  assign w_one      = {{(W_ACC-1){1'b0}}, 1'b1};
  assign w_ovf_next = r_ovf | w_acc_carry | w_beats_carry;

  // In DONE the upstream is gated by the consumer, so an accept there implies a handshake.
  assign I_READY  = (r_state == ACC) ? 1'b1 : O_READY;
  assign w_accept = I_VALID & I_READY;

  popcount_sat_add #(.W_ACC(W_ACC)) u_acc_add (
    .a     (r_acc),
    .b     (w_i_ext),
    .sum   (w_acc_sum),
    .carry (w_acc_carry)
  );

  popcount_sat_add #(.W_ACC(W_ACC)) u_beats_add (
    .a     (r_beats),
    .b     (w_one),
    .sum   (w_beats_sum),
    .carry (w_beats_carry)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state   <= ACC;
      r_acc     <= '0;
      r_beats   <= '0;
      r_ovf     <= 1'b0;
      r_o       <= '0;
      r_o_beats <= '0;
      r_o_ovf   <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept && I_LAST) begin
            r_o       <= w_acc_sum;
            r_o_beats <= w_beats_sum;
            r_o_ovf   <= w_ovf_next;
            r_o_valid <= 1'b1;
            r_acc     <= '0;
            r_beats   <= '0;
            r_ovf     <= 1'b0;
            r_state   <= DONE;
          end else if (w_accept) begin
            r_acc   <= w_acc_sum;
            r_beats <= w_beats_sum;
            r_ovf   <= w_ovf_next;
          end
        end
        DONE: begin
          // A same-cycle 1-beat frame reloads the result and keeps O_VALID high.
          if (w_accept && I_LAST) begin
            r_o       <= w_acc_sum;
            r_o_beats <= w_beats_sum;
            r_o_ovf   <= w_ovf_next;
            r_o_valid <= 1'b1;
            r_acc     <= '0;
            r_beats   <= '0;
            r_ovf     <= 1'b0;
          end else if (O_READY) begin
            if (w_accept) begin
              r_acc   <= w_acc_sum;
              r_beats <= w_beats_sum;
              r_ovf   <= w_ovf_next;
            end
            r_o_valid <= 1'b0;
            r_state   <= ACC;
          end
        end
        default: begin
          r_state   <= ACC;
          r_o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign O       = r_o;
  assign O_BEATS = r_o_beats;
  assign O_OVF   = r_o_ovf;
  assign O_VALID = r_o_valid;
endmodule

// File: doc/popcount_accum.md
# popcount_accum

Streaming accumulator that sits directly downstream of the 8-bit popcount stage (`PopCount8`). It takes one 4-bit per-byte count per accepted beat and sums counts over a frame delimited by `I_LAST`. It then presents the frame total, the beat count and an overflow flag on a valid/ready output port. It turns the combinational per-byte popcount into a per-frame Hamming weight for the downstream consumer.

## Interface
Parameters:
- `W_ACC`, 16: width of the frame total and beat counter; legal range 8..32.

Ports:
- `CLK`, input, 1: sole clock, rising edge.
- `ASYNCRESETN`, input, 1: reset, asynchronous, active-low.
- `I`, input, 4: per-byte popcount; legal range 0..8, values 9..15 are summed as-is.
- `I_VALID`, input, 1: `I`/`I_LAST` valid.
- `I_LAST`, input, 1: final beat of the frame.
- `I_READY`, output, 1: block can accept a beat.
- `O`, output, `W_ACC`: frame total.
- `O_BEATS`, output, `W_ACC`: number of beats in the frame, including the last.
- `O_OVF`, output, 1: total or beat counter exceeded `2^W_ACC-1` during the frame.
- `O_VALID`, output, 1: result valid.
- `O_READY`, input, 1: consumer accepts the result.

## Operation
- The FSM has two states, `ACC` and `DONE`. Reset state is `ACC` with `acc=0`, `beats=0` and `ovf=0`.
- A beat is accepted when `I_VALID && I_READY`. An output handshake occurs when `O_VALID && O_READY`.
- **`ACC` state:**
  - `I_READY=1`, `O_VALID=0`.
  - On an accepted non-last beat: `acc += I`, `beats += 1`, and `ovf |=` carry out of either sum.
  - On an accepted last beat: `O` is loaded with `acc+I`, `O_BEATS` with `beats+1`, and `O_OVF` with `ovf |` carries. Then `acc`, `beats` and `ovf` clear and the FSM goes to `DONE`.
- **`DONE` state:**
  - `O_VALID=1` and the outputs are held stable.
  - `I_READY=O_READY`, a combinational pass-through.
  - On an output handshake the FSM returns to `ACC`. If a beat is accepted in the same cycle, it is the first beat of the next frame and is accumulated from zero.
  - If that same-cycle beat is itself `I_LAST` (a 1-beat frame), the FSM stays in `DONE` and `O`/`O_BEATS`/`O_OVF` load the new result.
- Without a handshake, `DONE` persists indefinitely. No input is lost, because `I_READY=0` holds the upstream off.
- Arithmetic: `I` is zero-extended to `W_ACC` and the add is `W_ACC+1` bits wide. The top bit is the carry used for `ovf`. Wrap versus saturate behaviour is set under Configuration.
- Reset asserted mid-frame or in `DONE` discards all state immediately, with no output handshake.

## Timing
- All outputs are registered except `I_READY`. `I_READY` is combinational from state and `O_READY`; there is no path from `I_VALID`.
- Reset values: `I_READY=1`, `O_VALID=0`, `O=0`, `O_BEATS=0`, `O_OVF=0`.
- Latency: `O_VALID` rises on the clock edge that accepts the `I_LAST` beat, i.e. 1 cycle after the last beat is presented.
- Throughput: 1 beat/cycle sustained, including across frame boundaries, provided `O_READY=1` whenever `O_VALID=1`.
- `O`, `O_BEATS` and `O_OVF` change only on a last-beat accept or on reset.

## Configuration
- Macro: `POPCOUNT_ACCUM_SAT_EN`.
- **Defined:** `acc` and `beats` saturate at `2^W_ACC-1` on carry, so `O` and `O_BEATS` never wrap.
- **Undefined:** both wrap modulo `2^W_ACC`.
- `O_OVF` behaves identically in both builds.

## Structure
- Package `popcount_pkg` holds:
  - `W_CNT=4` and `MAX_CNT=8`.
  - State enum `popcount_accum_state_t {ACC, DONE}`.
  - Default `W_ACC=16`.
- One sub-module, `popcount_sat_add`, parameterised by `W_ACC`. It takes inputs `a` and `b` and produces a `sum` and a `carry`. The `POPCOUNT_ACCUM_SAT_EN` selection lives inside it. It is instantiated twice, once for `acc` and once for `beats`.

## Test plan
- **Basic frame:** frame of beats 3, 8, 0, 5 (last) with `O_READY=1` → one cycle after the last beat, `O=16`, `O_BEATS=4`, `O_OVF=0`, `O_VALID` high for one cycle.
- **Output backpressure:** `O_READY=0` for 5 cycles after `O_VALID` → `I_READY=0` throughout, outputs stable. `O_READY=1` → handshake, FSM back to `ACC`.
- **Back-to-back frames:** 1-beat frames 7 (last), 2 (last), 8 (last) on consecutive cycles with `O_READY=1` → `O` reads 7, 2, 8 on consecutive cycles and `O_BEATS=1` each.
- **Overflow:** `W_ACC=8`, 40 beats of 8 → `O_OVF=1`. `O=64` (320 mod 256) without the macro; `O=255` with it.
- **Reset mid-operation:** assert `ASYNCRESETN` low mid-frame after beats 4, 4, then release and send a frame of 6 (last) → `O=6`, `O_BEATS=1`. Also assert reset in `DONE` → `O_VALID` drops without waiting for a clock edge.
